// File: rtl/ones_accumulator.sv
// Accumulates ones-count samples into a saturating per-frame total and presents
// the frame sum, sample count and overflow flag with a valid/ready handshake.
module ones_accumulator #(
  parameter int unsigned Count_Width   = 4,
  parameter int unsigned Sum_Width     = 8,
  parameter int unsigned Samples_Width = 6,
  parameter int unsigned Frame_Len     = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [Count_Width-1:0]   In,
  input  logic                     In_Last,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [Sum_Width-1:0]     Out,
  output logic [Samples_Width-1:0] Out_Samples,
  output logic                     Out_Overflow
);

  localparam int unsigned                SumExtW   = Sum_Width + 1;
  localparam logic [Sum_Width-1:0]       SumMax    = '1;
  localparam logic [Samples_Width-1:0]   FrameLenS = Samples_Width'(Frame_Len);
  localparam logic [Samples_Width-1:0]   OneS      = Samples_Width'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [Sum_Width-1:0]     sum_q, sum_d;
  logic [Samples_Width-1:0] samples_q, samples_d;
  logic                     ovf_q, ovf_d;

  logic                     in_fire;
  logic [SumExtW-1:0]       sum_base;
  logic [SumExtW-1:0]       sum_wide;
  logic                     sat;
  logic [Samples_Width-1:0] samples_inc;

  // Handshake flags are a pure decode of the registered state.
  assign In_Ready     = (state_q != HOLD);
  assign Out_Valid    = (state_q == HOLD);
  assign Out          = sum_q;
  assign Out_Samples  = samples_q;
  assign Out_Overflow = ovf_q;

  // Next-state and accumulator update; a frame start seeds from zero.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    samples_d   = samples_q;
    ovf_d       = ovf_q;
    in_fire     = In_Valid && (state_q != HOLD);
    sum_base    = (state_q == ACCUM) ? SumExtW'(sum_q) : '0;
    sum_wide    = sum_base + SumExtW'(In);
    sat         = sum_wide[Sum_Width];
    samples_inc = (state_q == ACCUM) ? (samples_q + OneS) : OneS;

    case (state_q)
      IDLE, ACCUM: begin
        if (in_fire) begin
          sum_d     = sat ? SumMax : sum_wide[Sum_Width-1:0];
          samples_d = samples_inc;
          ovf_d     = sat || ((state_q == ACCUM) && ovf_q);
          state_d   = (In_Last || (samples_inc == FrameLenS)) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (Out_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      samples_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      samples_q <= samples_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: doc/ones_accumulator.md
ONES_ACCUMULATOR -- requirements
Module: ones_accumulator

Interface
REQ-001 Parameter Count_Width, default 4: width of each incoming ones-count sample.
REQ-002 Parameter Sum_Width, default 8: width of the accumulated frame total.
REQ-003 Parameter Samples_Width, default 6: width of the per-frame sample counter.
REQ-004 Parameter Frame_Len, default 32: maximum samples per frame, legal range 1 to 2^Samples_Width-1.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Rst  input  1  synchronous, active-high reset.
REQ-007 In_Valid  input  1  In carries a valid sample.
REQ-008 In_Ready  output  1  block can accept a sample this cycle.
REQ-009 In  input  Count_Width  ones-count sample, unsigned.
REQ-010 In_Last  input  1  qualifies In as the final sample of the frame.
REQ-011 Out_Valid  output  1  frame result available.
REQ-012 Out_Ready  input  1  downstream accepts the result.
REQ-013 Out  output  Sum_Width  saturated sum of the frame's samples.
REQ-014 Out_Samples  output  Samples_Width  number of samples in the frame.
REQ-015 Out_Overflow  output  1  sum saturated during the frame.

Function
REQ-016 One clock domain, one synchronous active-high reset; no other reset or clock inputs.
REQ-017 Input transfer occurs only in a cycle where In_Valid and In_Ready are both 1; output transfer only where Out_Valid and Out_Ready are both 1.
REQ-018 FSM has three states: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
REQ-019 In_Ready = 1 in IDLE and ACCUM, 0 in HOLD; Out_Valid = 1 only in HOLD; both decoded from registered state.
REQ-020 IDLE, on transfer: sum <= In, samples <= 1, overflow <= 0; go to HOLD if In_Last=1 or Frame_Len=1, else ACCUM.
REQ-021 ACCUM, on transfer: sum <= sum + In, samples <= samples + 1; go to HOLD if In_Last=1 or samples+1 = Frame_Len, else stay.
REQ-022 Addition performed at Sum_Width+1 bits; result above 2^Sum_Width-1 saturates to 2^Sum_Width-1 and sets overflow, which stays set until next frame start.
REQ-023 Once saturated, further samples keep sum at max, still increment samples.
REQ-024 IDLE or ACCUM with no transfer: all state held (bubbles ignored).
REQ-025 HOLD: Out, Out_Samples, Out_Overflow stable; on output transfer go to IDLE; inputs ignored.
REQ-026 Latency: Out_Valid rises the cycle after the final input transfer; frames are never merged and no sample is dropped.
REQ-027 No same-cycle bypass: a sample presented in the cycle HOLD exits is not accepted; first sample of next frame accepted one cycle after output transfer at earliest.
REQ-028 In values are not range-checked; any value 0 to 2^Count_Width-1 is summed.
REQ-029 Out, Out_Samples, Out_Overflow are registers driven from the accumulator; values outside HOLD are don't-care for downstream but deterministic.

Reset
REQ-030 Rst=1 on a rising edge forces IDLE, sum=0, samples=0, overflow=0, regardless of state.
REQ-031 Post-reset outputs: In_Ready=1, Out_Valid=0, Out=0, Out_Samples=0, Out_Overflow=0.
REQ-032 Reset during ACCUM or HOLD discards the partial or pending frame; no result emitted for it.
REQ-033 Rst has priority over any simultaneous transfer.

Verification
REQ-034 Reset, hold inputs idle 5 cycles -> In_Ready=1, Out_Valid=0, Out=0, Out_Samples=0, Out_Overflow=0 throughout.
REQ-035 Samples 3,5,7, In_Last on third, Out_Ready=1 -> Out_Valid=1 the cycle after third transfer, Out=15, Out_Samples=3, Out_Overflow=0; IDLE next cycle.
REQ-036 32 samples of value 8, no In_Last -> frame closes at 32nd sample, Out=255, Out_Samples=32, Out_Overflow=1.
REQ-037 Result pending with Out_Ready=0 for 5 cycles, In_Valid=1 -> In_Ready=0, outputs unchanged, no sample accepted; Out_Ready=1 -> IDLE next cycle, following sample starts a new frame with Out_Samples counting from 1.
REQ-038 10 samples of value 2 then Rst=1 one cycle, then samples 1,1 with In_Last -> Out=2, Out_Samples=2, Out_Overflow=0.
REQ-039 Samples 4,4,4 with In_Valid low on alternating cycles, In_Last on third -> Out=12, Out_Samples=3; bubble cycles change nothing.
